// File: rtl/cpu_param.sv
// Parametrised single-cycle processor core: 16 registers, external async-read ROM,
// memory-mapped style I/O ports, return-address stack with sticky overflow/underflow halt.
module cpu_param #(
    parameter int DATA_W      = 8,
    parameter int NREGS       = 16,
    parameter int NPORTS      = 4,
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [15:0]              imem_data,
    input  logic [NPORTS*DATA_W-1:0] in_ports,
    output logic [NPORTS*DATA_W-1:0] out_ports,
    output logic                     halted,
    output logic                     stack_err
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic              z_q, z_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] regs_q  [NREGS];
    logic [DATA_W-1:0] regs_d  [NREGS];
    logic [DATA_W-1:0] out_q   [NPORTS];
    logic [DATA_W-1:0] out_d   [NPORTS];
    logic [PC_W-1:0]   stack_q [STACK_DEPTH];
    logic [PC_W-1:0]   stack_d [STACK_DEPTH];
    logic [DATA_W-1:0] in_arr  [NPORTS];

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_ports
            assign in_arr[gi]                      = in_ports[gi*DATA_W +: DATA_W];
            assign out_ports[gi*DATA_W +: DATA_W] = out_q[gi];
        end
    endgenerate

    assign imem_addr = pc_q;
    assign halted    = halted_q;
    assign stack_err = err_q;

    logic [3:0]        opcode, ra_idx, rb_idx, rd_idx;
    logic [DATA_W-1:0] ra_val, rb_val, alu_res, in_val;
    logic [PC_W-1:0]   pc_inc, target, ret_addr;
    logic              stack_full, stack_empty;

    always_comb begin
        opcode      = imem_data[15:12];
        ra_idx      = imem_data[11:8];
        rb_idx      = imem_data[7:4];
        rd_idx      = imem_data[3:0];
        ra_val      = regs_q[ra_idx];
        rb_val      = regs_q[rb_idx];
        pc_inc      = pc_q + PC_W'(1);
        target      = imem_data[PC_W-1:0];
        stack_full  = (sp_q == SP_W'(STACK_DEPTH));
        stack_empty = (sp_q == '0);

        unique case (imem_data[14:12])
            3'b000:  alu_res = ra_val;
            3'b001:  alu_res = ~ra_val;
            3'b010:  alu_res = ra_val + rb_val;
            3'b011:  alu_res = ra_val - rb_val;
            3'b100:  alu_res = ra_val & rb_val;
            3'b101:  alu_res = ra_val | rb_val;
            3'b110:  alu_res = -ra_val;
            default: alu_res = -rb_val;
        endcase

        // Out-of-range port indices read as zero rather than aliasing
        in_val = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (imem_data[11:4] == p[7:0]) in_val = in_arr[p];
        end

        ret_addr = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) ret_addr = stack_q[i];
        end
    end

    always_comb begin
        pc_d     = pc_q;
        z_d      = z_q;
        sp_d     = sp_q;
        halted_d = halted_q;
        err_d    = err_q;
        regs_d   = regs_q;
        out_d    = out_q;
        stack_d  = stack_q;

        if (!halted_q) begin
            pc_d = pc_inc;
            if (!opcode[3]) begin
                z_d = (alu_res == '0);
                if (rd_idx != 4'd0) regs_d[rd_idx] = alu_res;
            end else begin
                unique case (opcode[2:0])
                    3'b000: if (rd_idx != 4'd0) regs_d[rd_idx] = DATA_W'(imem_data[11:4]);
                    3'b001: if (rd_idx != 4'd0) regs_d[rd_idx] = in_val;
                    3'b010: begin
                        for (int p = 0; p < NPORTS; p++) begin
                            if (imem_data[7:0] == p[7:0]) out_d[p] = ra_val;
                        end
                    end
                    3'b011: pc_d = target;
                    3'b100: if (z_q) pc_d = target;
                    3'b101: if (!z_q) pc_d = target;
                    3'b110: begin
                        if (stack_full) begin
                            pc_d     = pc_q;
                            err_d    = 1'b1;
                            halted_d = 1'b1;
                        end else begin
                            for (int i = 0; i < STACK_DEPTH; i++) begin
                                if (sp_q == SP_W'(i)) stack_d[i] = pc_inc;
                            end
                            sp_d = sp_q + SP_W'(1);
                            pc_d = target;
                        end
                    end
                    default: begin
                        if (ra_idx == 4'h0) begin
                            if (stack_empty) begin
                                pc_d     = pc_q;
                                err_d    = 1'b1;
                                halted_d = 1'b1;
                            end else begin
                                sp_d = sp_q - SP_W'(1);
                                pc_d = ret_addr;
                            end
                        end else if (ra_idx == 4'h1) begin
                            pc_d     = pc_q;
                            halted_d = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            z_q      <= 1'b0;
            sp_q     <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++)       regs_q[i]  <= '0;
            for (int i = 0; i < NPORTS; i++)      out_q[i]   <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            z_q      <= z_d;
            sp_q     <= sp_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            regs_q   <= regs_d;
            out_q    <= out_d;
            stack_q  <= stack_d;
        end
    end
endmodule

// File: tb/tb_cpu_param.sv
// Directed-program testbench for cpu_param: small programs in a bench-side ROM,
// results observed through out_ports, imem_addr, halted and stack_err.
module tb_cpu_param;
    localparam int DATA_W = 8;
    localparam int NPORTS = 4;
    localparam int PC_W   = 10;
    localparam int DEPTH  = 2;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [PC_W-1:0]          imem_addr;
    logic [15:0]              imem_data;
    logic [NPORTS*DATA_W-1:0] in_ports = '0;
    logic [NPORTS*DATA_W-1:0] out_ports;
    logic                     halted;
    logic                     stack_err;
    logic [15:0]              rom [1 << PC_W];

    int tests_run    = 0;
    int tests_failed = 0;

    cpu_param #(.DATA_W(DATA_W), .NREGS(16), .NPORTS(NPORTS), .PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .in_ports(in_ports), .out_ports(out_ports), .halted(halted), .stack_err(stack_err)
    );

    assign imem_data = rom[imem_addr];
    always #5 clk = ~clk;

    function automatic logic [15:0] i_alu(input logic [2:0] op, input logic [3:0] ra, rb, rd);
        return {1'b0, op, ra, rb, rd};
    endfunction
    function automatic logic [15:0] i_ldi(input logic [3:0] rd, input logic [7:0] imm);
        return {4'h8, imm, rd};
    endfunction
    function automatic logic [15:0] i_in(input logic [3:0] rd, input logic [7:0] p);
        return {4'h9, p, rd};
    endfunction
    function automatic logic [15:0] i_out(input logic [3:0] ra, input logic [7:0] p);
        return {4'hA, ra, p};
    endfunction
    function automatic logic [15:0] i_br(input logic [3:0] op, input int t);
        return {op, 2'b00, t[9:0]};
    endfunction
    localparam logic [15:0] I_RET  = 16'hF000;
    localparam logic [15:0] I_HALT = 16'hF100;
    localparam logic [15:0] I_NOP  = 16'hF200;

    task automatic clear_rom();
        for (int i = 0; i < (1 << PC_W); i++) rom[i] = I_NOP;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        clear_rom();
        apply_reset();
        tests_run++;
        if (imem_addr !== 10'd0 || halted !== 1'b0 || stack_err !== 1'b0 || out_ports !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state: pc=%0h halted=%b err=%b out=%h, want pc=0 halted=0 err=0 out=0",
                     imem_addr, halted, stack_err, out_ports);
        end
        $display("[TB] reset: pc=%0h halted=%b err=%b out=%h", imem_addr, halted, stack_err, out_ports);
    endtask

    task automatic test_alu();
        clear_rom();
        rom[0]  = i_ldi(4'd1, 8'd5);
        rom[1]  = i_ldi(4'd2, 8'd5);
        rom[2]  = i_alu(3'b011, 4'd1, 4'd2, 4'd3);
        rom[3]  = i_br(4'hC, 8);
        rom[8]  = i_alu(3'b010, 4'd1, 4'd2, 4'd4);
        rom[9]  = i_out(4'd3, 8'd0);
        rom[10] = i_out(4'd4, 8'd1);
        rom[11] = i_br(4'hD, 20);
        rom[12] = I_HALT;
        rom[20] = I_HALT;
        apply_reset();
        step(4);
        tests_run++;
        if (imem_addr !== 10'd8) begin
            tests_failed++;
            $display("FAIL alu_sub_jz: pc=%0d, want 8", imem_addr);
        end
        step(4);
        tests_run++;
        if (imem_addr !== 10'd20 || out_ports[15:0] !== 16'h0A00) begin
            tests_failed++;
            $display("FAIL alu_add_jnz: pc=%0d ports01=%h, want pc=20 ports01=0a00", imem_addr, out_ports[15:0]);
        end
        step(2);
        tests_run++;
        if (imem_addr !== 10'd20 || halted !== 1'b1 || stack_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_instr: pc=%0d halted=%b err=%b, want pc=20 halted=1 err=0", imem_addr, halted, stack_err);
        end
        $display("[TB] alu: pc=%0d out=%h halted=%b", imem_addr, out_ports, halted);
    endtask

    task automatic test_wrap();
        clear_rom();
        rom[0] = i_ldi(4'd5, 8'h33);
        rom[1] = i_out(4'd5, 8'd2);
        rom[2] = i_ldi(4'd1, 8'hFF);
        rom[3] = i_ldi(4'd2, 8'h01);
        rom[4] = i_alu(3'b010, 4'd1, 4'd2, 4'd3);
        rom[5] = i_br(4'hC, 7);
        rom[6] = I_HALT;
        rom[7] = i_out(4'd3, 8'd2);
        rom[8] = I_HALT;
        apply_reset();
        step(2);
        tests_run++;
        if (out_ports[23:16] !== 8'h33) begin
            tests_failed++;
            $display("FAIL wrap_preset: port2=%h, want 33", out_ports[23:16]);
        end
        step(7);
        tests_run++;
        if (imem_addr !== 10'd8 || halted !== 1'b1 || out_ports[23:16] !== 8'h00) begin
            tests_failed++;
            $display("FAIL wrap_add: pc=%0d halted=%b port2=%h, want pc=8 halted=1 port2=00",
                     imem_addr, halted, out_ports[23:16]);
        end
        $display("[TB] wrap: pc=%0d port2=%h", imem_addr, out_ports[23:16]);
    endtask

    task automatic test_ports();
        clear_rom();
        in_ports = {8'h44, 8'hA5, 8'h22, 8'h11};
        rom[0] = i_in(4'd1, 8'd2);
        rom[1] = i_out(4'd1, 8'd3);
        rom[2] = i_out(4'd1, 8'd0);
        rom[3] = i_out(4'd1, 8'd7);
        rom[4] = i_in(4'd1, 8'd9);
        rom[5] = i_out(4'd1, 8'd0);
        rom[6] = I_HALT;
        apply_reset();
        step(1);
        tests_run++;
        if (out_ports !== 32'h0) begin
            tests_failed++;
            $display("FAIL port_in_only: out=%h, want 00000000", out_ports);
        end
        step(1);
        tests_run++;
        if (out_ports !== 32'hA5000000) begin
            tests_failed++;
            $display("FAIL port_out3: out=%h, want a5000000", out_ports);
        end
        step(2);
        tests_run++;
        if (out_ports !== 32'hA50000A5) begin
            tests_failed++;
            $display("FAIL port_out7_ignored: out=%h, want a50000a5", out_ports);
        end
        step(2);
        tests_run++;
        if (out_ports !== 32'hA5000000) begin
            tests_failed++;
            $display("FAIL port_in9_zero: out=%h, want a5000000", out_ports);
        end
        in_ports = '0;
        $display("[TB] ports: out=%h", out_ports);
    endtask

    task automatic test_stack();
        clear_rom();
        rom[3]    = i_br(4'hE, 32'h20);
        rom[4]    = i_ldi(4'd1, 8'h77);
        rom[5]    = i_out(4'd1, 8'd1);
        rom[6]    = I_HALT;
        rom[32'h20] = I_RET;
        apply_reset();
        step(4);
        tests_run++;
        if (imem_addr !== 10'h20) begin
            tests_failed++;
            $display("FAIL call_target: pc=%0h, want 20", imem_addr);
        end
        step(1);
        tests_run++;
        if (imem_addr !== 10'd4 || halted !== 1'b0 || stack_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL ret_addr: pc=%0h halted=%b err=%b, want pc=4 halted=0 err=0", imem_addr, halted, stack_err);
        end
        step(2);
        tests_run++;
        if (out_ports[15:8] !== 8'h77 || imem_addr !== 10'd6) begin
            tests_failed++;
            $display("FAIL after_ret: port1=%h pc=%0d, want port1=77 pc=6", out_ports[15:8], imem_addr);
        end
        $display("[TB] stack: pc=%0h out=%h", imem_addr, out_ports);
    endtask

    task automatic test_overflow();
        clear_rom();
        rom[0]      = i_ldi(4'd1, 8'h5A);
        rom[1]      = i_out(4'd1, 8'd0);
        rom[2]      = i_br(4'hE, 32'h10);
        rom[32'h10] = i_br(4'hE, 32'h20);
        rom[32'h20] = i_br(4'hE, 32'h30);
        rom[32'h30] = i_out(4'd1, 8'd3);
        apply_reset();
        step(4);
        tests_run++;
        if (imem_addr !== 10'h20 || halted !== 1'b0 || stack_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL second_call: pc=%0h halted=%b err=%b, want pc=20 halted=0 err=0", imem_addr, halted, stack_err);
        end
        step(1);
        tests_run++;
        if (imem_addr !== 10'h20 || halted !== 1'b1 || stack_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow: pc=%0h halted=%b err=%b, want pc=20 halted=1 err=1", imem_addr, halted, stack_err);
        end
        for (int c = 0; c < 10; c++) begin
            step(1);
            tests_run++;
            if (imem_addr !== 10'h20 || out_ports !== 32'h0000005A || halted !== 1'b1) begin
                tests_failed++;
                $display("FAIL overflow_frozen[%0d]: pc=%0h out=%h halted=%b, want pc=20 out=0000005a halted=1",
                         c, imem_addr, out_ports, halted);
            end
        end
        $display("[TB] overflow: pc=%0h err=%b out=%h", imem_addr, stack_err, out_ports);
    endtask

    task automatic test_underflow_reset();
        clear_rom();
        rom[0] = i_ldi(4'd1, 8'h11);
        rom[1] = i_out(4'd1, 8'd3);
        rom[2] = I_RET;
        apply_reset();
        step(3);
        tests_run++;
        if (imem_addr !== 10'd2 || halted !== 1'b1 || stack_err !== 1'b1 || out_ports !== 32'h11000000) begin
            tests_failed++;
            $display("FAIL underflow: pc=%0d halted=%b err=%b out=%h, want pc=2 halted=1 err=1 out=11000000",
                     imem_addr, halted, stack_err, out_ports);
        end
        clear_rom();
        rom[0] = I_HALT;
        apply_reset();
        tests_run++;
        if (imem_addr !== 10'd0 || halted !== 1'b0 || stack_err !== 1'b0 || out_ports !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_clears: pc=%0d halted=%b err=%b out=%h, want all 0",
                     imem_addr, halted, stack_err, out_ports);
        end
        step(1);
        tests_run++;
        if (imem_addr !== 10'd0 || halted !== 1'b1 || stack_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_no_err: pc=%0d halted=%b err=%b, want pc=0 halted=1 err=0", imem_addr, halted, stack_err);
        end
        apply_reset();
        tests_run++;
        if (halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_halt: halted=%b, want 0", halted);
        end
        $display("[TB] underflow/reset: pc=%0d halted=%b err=%b", imem_addr, halted, stack_err);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_wrap();
        test_ports();
        test_stack();
        test_overflow();
        test_underflow_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/cpu_param.md
Name: cpu_param

Overview:
- Parametrised single-cycle processor core, successor to the fixed 8-bit, 4-port core.
- Data width, register count, I/O port count, PC width and return-stack depth are all generic.
- Adds sticky stack overflow/underflow detection and a HALT state.
- Instruction memory is external: asynchronous-read ROM on imem_addr/imem_data. No data memory.

Parameters:
DATA_W, 8, datapath and register width (>= 8)
NREGS, 16, register file entries (fixed at 16, 4-bit indices); R0 reads 0 and ignores writes
NPORTS, 4, input and output port count (1..256)
PC_W, 10, program counter width (<= 12)
STACK_DEPTH, 8, return-address stack entries (>= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high
imem_addr  output  PC_W  instruction address, equals PC combinationally
imem_data  input  16  instruction word, valid same cycle (async ROM)
in_ports  input  NPORTS*DATA_W  input port p at bits [p*DATA_W +: DATA_W]
out_ports  output  NPORTS*DATA_W  registered output ports, same packing
halted  output  1  high once HALT executed or stack error, until reset
stack_err  output  1  sticky: CALL on full or RET on empty stack

Behaviour:
- Reset (sync): PC=0, all regs=0, out_ports=0, Z=0, SP=0, halted=0, stack_err=0. Reset wins over any instruction in the same cycle, including mid-HALT.
- One instruction per cycle: decode imem_data, write results at the next edge. PC+1 wraps modulo 2^PC_W.
- Jump targets: instr[PC_W-1:0].
- Encoding by instr[15:12]; ra=[11:8], rb=[7:4], rd=[3:0]:
  - 0xxx ALU: rd <= f(ra,rb), with op=instr[14:12]: 000 ra, 001 ~ra, 010 ra+rb, 011 ra-rb, 100 ra&rb, 101 ra|rb, 110 -ra, 111 -rb.
  - ALU results are modulo 2^DATA_W. Z <= (result==0), updated even when rd=R0.
  - 1000 LDI: rd <= zero-extended instr[11:4]. Z unchanged.
  - 1001 IN: rd <= in_ports[instr[11:4]]. Index >= NPORTS reads 0. Z unchanged.
  - 1010 OUT: out_ports[instr[7:0]] <= reg[ra]. Index >= NPORTS is ignored. Output is visible the cycle after execution.
  - 1011 J: PC <= target.
  - 1100 JZ: PC <= Z ? target : PC+1.
  - 1101 JNZ: PC <= !Z ? target : PC+1.
  - 1110 CALL:
    - Stack not full: stack[SP] <= PC+1, SP++, PC <= target.
    - Full (SP==STACK_DEPTH): no push, stack_err=1, halted=1, PC holds.
  - 1111 SYS, sub-op instr[11:8]:
    - 0000 RET, not empty: SP--, PC <= stack[SP-1].
    - 0000 RET, empty: stack_err=1, halted=1, PC holds.
    - 0001 HALT: halted=1, PC holds.
    - All other sub-ops are NOP (PC+1).
- Halted state: PC frozen, no register, port, Z or SP updates. imem_addr stays at the halting instruction. Only reset exits.
- Register reads are combinational; writes happen at the edge. Read-after-write to the same register on the next instruction sees the new value. No bypass needed (single cycle).
- SP width: clog2(STACK_DEPTH+1). Full when SP==STACK_DEPTH, empty when SP==0.
- No X propagation: unused register/stack entries reset to 0.

Test Plan:
- Reset/ALU: LDI R1,5; LDI R2,5; SUB R3=R1-R2; JZ 8 -> R3=0, Z=1, PC=8 at cycle 4. Then ADD R4=R1+R2 -> R4=10, Z=0.
- Wrap: LDI R1,0xFF; LDI R2,1; ADD R3 (DATA_W=8) -> R3=0x00, Z=1. With DATA_W=16 -> R3=0x0100, Z=0.
- Ports (NPORTS=4): in_ports[2]=0xA5; IN R1,2; OUT R1 to port 3 -> out_ports[3]=0xA5 one cycle later. OUT to port 7 -> all out_ports unchanged. IN from port 9 -> R1=0.
- Stack: CALL 0x20 at PC=3; at 0x20 RET -> PC=4, SP back to 0.
- Stack overflow (STACK_DEPTH=2): CALL at the target of the second CALL -> stack_err=1 and halted=1. PC frozen for 10 cycles; out_ports unchanged.
- Underflow and reset: RET at PC=0 -> stack_err=1, halted=1. Assert reset for 1 cycle -> PC=0, halted=0, stack_err=0, out_ports=0. A HALT instruction -> halted=1, stack_err=0.
